// File: rtl/pc_sequencer.sv
// Next-PC sequencer: selects PC_In/Enable from redirects, stall and debug run/step state; keeps exec counters.
// Latency: PC_In/Enable combinational (redirects take effect on the same edge); Flush_IF/Halted/counters registered.
// Backpressure: Stall holds Enable low; redirects seen while stalled are buffered and applied on the first advance.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [31:0] PCResult,
   input  logic        Stall,
   input  logic        Branch_Taken,
   input  logic [31:0] Branch_Target,
   input  logic        Jump,
   input  logic [31:0] Jump_Target,
   input  logic        Halt_Instr,
   input  logic        Dbg_Run,
   input  logic        Dbg_Step,
   input  logic        Dbg_Stop,
   output logic [31:0] PC_In,
   output logic        Enable,
   output logic        Flush_IF,
   output logic        Halted,
   output logic [31:0] Instr_Count,
   output logic [31:0] Cycle_Count
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_RUN    = 2'd1;
   localparam logic [1:0] S_STEP   = 2'd2;
   localparam logic [1:0] S_HALTED = 2'd3;

   logic [1:0]  state_q, state_d;
   logic        pend_valid_q, pend_valid_d;
   logic [31:0] pend_target_q, pend_target_d;
   logic        flush_q, flush_d;
   logic        halted_q, halted_d;
   logic [31:0] icnt_q, icnt_d;
   logic [31:0] ccnt_q, ccnt_d;

   logic        active;
   logic        advance;
   logic        redir_vld;
   logic [31:0] redir_tgt;

   // Fetch qualification and redirect selection (jump beats branch, word aligned)
   always_comb begin
      active    = (state_q == S_RUN) || (state_q == S_STEP);
      advance   = active && !Stall && !Halt_Instr;
      redir_vld = Jump || Branch_Taken;
      redir_tgt = Jump ? (Jump_Target & ~32'h3) : (Branch_Target & ~32'h3);
   end

   // Next PC: new redirect, else buffered redirect, else sequential
   always_comb begin
      if (redir_vld) begin
         PC_In = redir_tgt;
      end else if (pend_valid_q) begin
         PC_In = pend_target_q;
      end else begin
         PC_In = PCResult + 32'd4;
      end
      Enable = advance;
   end

   // Debug-controlled run state; HALTED is left only through reset
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (Dbg_Run) begin
               state_d = S_RUN;
            end else if (Dbg_Step) begin
               state_d = S_STEP;
            end
         end
         S_RUN: begin
            if (Halt_Instr) begin
               state_d = S_HALTED;
            end else if (Dbg_Stop) begin
               state_d = S_IDLE;
            end
         end
         S_STEP: begin
            if (Halt_Instr) begin
               state_d = S_HALTED;
            end else if (advance) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_HALTED;
      endcase
   end

   // Pending redirect buffer, flush request and counters
   always_comb begin
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;
      if (advance) begin
         pend_valid_d = 1'b0;
      end else if (redir_vld) begin
         pend_valid_d  = 1'b1;
         pend_target_d = redir_tgt;
      end
      flush_d  = advance && (redir_vld || pend_valid_q);
      halted_d = (state_d == S_HALTED);
      icnt_d   = advance ? icnt_q + 32'd1 : icnt_q;
      ccnt_d   = active  ? ccnt_q + 32'd1 : ccnt_q;
   end

   // State registers; reset arms a pending redirect to RESET_PC for the first fetch
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q       <= S_IDLE;
         pend_valid_q  <= 1'b1;
         pend_target_q <= RESET_PC;
         flush_q       <= 1'b0;
         halted_q      <= 1'b0;
         icnt_q        <= 32'd0;
         ccnt_q        <= 32'd0;
      end else begin
         state_q       <= state_d;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
         flush_q       <= flush_d;
         halted_q      <= halted_d;
         icnt_q        <= icnt_d;
         ccnt_q        <= ccnt_d;
      end
   end

   assign Flush_IF    = flush_q;
   assign Halted      = halted_q;
   assign Instr_Count = icnt_q;
   assign Cycle_Count = ccnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer with a queue-based scoreboard.
// Stimulus drives one vector per cycle just after the rising edge and queues the hand-computed outputs.
// A monitor pops and compares on every falling edge.
module tb_pc_sequencer;

   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic [31:0] PCResult = '0;
   logic        Stall = 1'b0;
   logic        Branch_Taken = 1'b0;
   logic [31:0] Branch_Target = '0;
   logic        Jump = 1'b0;
   logic [31:0] Jump_Target = '0;
   logic        Halt_Instr = 1'b0;
   logic        Dbg_Run = 1'b0;
   logic        Dbg_Step = 1'b0;
   logic        Dbg_Stop = 1'b0;
   logic [31:0] PC_In;
   logic        Enable;
   logic        Flush_IF;
   logic        Halted;
   logic [31:0] Instr_Count;
   logic [31:0] Cycle_Count;

   pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
      .Clock(Clock), .Reset(Reset), .PCResult(PCResult), .Stall(Stall),
      .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
      .Jump(Jump), .Jump_Target(Jump_Target), .Halt_Instr(Halt_Instr),
      .Dbg_Run(Dbg_Run), .Dbg_Step(Dbg_Step), .Dbg_Stop(Dbg_Stop),
      .PC_In(PC_In), .Enable(Enable), .Flush_IF(Flush_IF), .Halted(Halted),
      .Instr_Count(Instr_Count), .Cycle_Count(Cycle_Count)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      int          idx;
      logic [31:0] pc;
      logic        en;
      logic        fl;
      logic        ha;
      logic [31:0] ic;
      logic [31:0] cc;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   vnum  = 0;

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, req);
      end
   endtask

   // Monitor: compare whatever the current cycle's expectation is
   always @(negedge Clock) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("pc_in",       e.idx, PC_In,       e.pc);
         chk("enable",      e.idx, {31'd0, Enable},   {31'd0, e.en});
         chk("flush_if",    e.idx, {31'd0, Flush_IF}, {31'd0, e.fl});
         chk("halted",      e.idx, {31'd0, Halted},   {31'd0, e.ha});
         chk("instr_count", e.idx, Instr_Count, e.ic);
         chk("cycle_count", e.idx, Cycle_Count, e.cc);
      end
   end

   // One cycle of stimulus plus its expected outputs
   task automatic vec(
      input logic rst, input logic [31:0] pcr, input logic st,
      input logic br, input logic [31:0] bt, input logic j, input logic [31:0] jt,
      input logic hlt, input logic run, input logic stp, input logic stop,
      input logic [31:0] epc, input logic een, input logic efl, input logic eha,
      input logic [31:0] eic, input logic [31:0] ecc);
      exp_t e;
      @(posedge Clock);
      #1;
      Reset = rst; PCResult = pcr; Stall = st;
      Branch_Taken = br; Branch_Target = bt; Jump = j; Jump_Target = jt;
      Halt_Instr = hlt; Dbg_Run = run; Dbg_Step = stp; Dbg_Stop = stop;
      vnum++;
      e.idx = vnum; e.pc = epc; e.en = een; e.fl = efl; e.ha = eha; e.ic = eic; e.cc = ecc;
      exp_q.push_back(e);
   endtask

   initial begin
      //   rst pcr           st br bt            j  jt            h  r  s  p    pc            en fl ha ic  cc
      // reset state
      vec(0, 32'h0,         0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'h0,        0, 0, 0, 0,  0);
      vec(1, 32'h0,         0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 0,  32'h0,        0, 0, 0, 0,  0);
      // sequential run 0,4,8,12
      vec(1, 32'h0,         0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'h0,        1, 0, 0, 0,  0);
      vec(1, 32'h0,         0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'h4,        1, 1, 0, 1,  1);
      vec(1, 32'h4,         0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'h8,        1, 0, 0, 2,  2);
      vec(1, 32'h8,         0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'hC,        1, 0, 0, 3,  3);
      // branch with unaligned target, then jump beating branch
      vec(1, 32'h10,        0, 1, 32'h0AA3,     0, 32'h0,        0, 0, 0, 0,  32'h0AA0,     1, 0, 0, 4,  4);
      vec(1, 32'h0AA0,      0, 1, 32'h0AA3,     1, 32'h40,       0, 0, 0, 0,  32'h40,       1, 1, 0, 5,  5);
      // branch during 3-cycle stall
      vec(1, 32'h40,        1, 1, 32'h100,      0, 32'h0,        0, 0, 0, 0,  32'h100,      0, 1, 0, 6,  6);
      vec(1, 32'h40,        1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'h100,      0, 0, 0, 6,  7);
      vec(1, 32'h40,        1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'h100,      0, 0, 0, 6,  8);
      vec(1, 32'h40,        0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'h100,      1, 0, 0, 6,  9);
      vec(1, 32'h100,       0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'h104,      1, 1, 0, 7,  10);
      // wrap, then stop
      vec(1, 32'hFFFF_FFFC, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'h0,        1, 0, 0, 8,  11);
      vec(1, 32'h0,         0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 1,  32'h4,        1, 0, 0, 9,  12);
      vec(1, 32'h4,         0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'h8,        0, 0, 0, 10, 13);
      // single step blocked by two stall cycles
      vec(1, 32'h4,         0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 0,  32'h8,        0, 0, 0, 10, 13);
      vec(1, 32'h4,         1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'h8,        0, 0, 0, 10, 13);
      vec(1, 32'h4,         1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'h8,        0, 0, 0, 10, 14);
      vec(1, 32'h4,         0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'h8,        1, 0, 0, 10, 15);
      // back in IDLE; run and step together -> run
      vec(1, 32'h8,         0, 0, 32'h0,        0, 32'h0,        0, 1, 1, 0,  32'hC,        0, 0, 0, 11, 16);
      vec(1, 32'h8,         0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'hC,        1, 0, 0, 11, 16);
      // HALT at 0x24, then debug pulses ignored
      vec(1, 32'h24,        0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 0,  32'h28,       0, 0, 0, 12, 17);
      vec(1, 32'h24,        0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 0,  32'h28,       0, 0, 1, 12, 18);
      vec(1, 32'h24,        0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 0,  32'h28,       0, 0, 1, 12, 18);
      vec(1, 32'h24,        0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'h28,       0, 0, 1, 12, 18);
      // reset out of HALTED
      vec(0, 32'h24,        0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'h0,        0, 0, 0, 0,  0);
      vec(1, 32'h28,        0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 0,  32'h0,        0, 0, 0, 0,  0);
      vec(1, 32'h28,        0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'h0,        1, 0, 0, 0,  0);
      vec(1, 32'h0,         0, 0, 32'h0,        1, 32'h203,      0, 0, 0, 0,  32'h200,      1, 1, 0, 1,  1);
      // buffer a redirect, then reset mid-run
      vec(1, 32'h200,       1, 1, 32'h300,      0, 32'h0,        0, 0, 0, 0,  32'h300,      0, 1, 0, 2,  2);
      vec(1, 32'h200,       1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'h300,      0, 0, 0, 2,  3);
      vec(0, 32'h200,       1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'h0,        0, 0, 0, 0,  0);
      vec(1, 32'h200,       0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 0,  32'h0,        0, 0, 0, 0,  0);
      vec(1, 32'h200,       0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'h0,        1, 0, 0, 0,  0);
      vec(1, 32'h0,         0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  32'h4,        1, 1, 0, 1,  1);

      // let the monitor drain, bounded
      for (int k = 0; k < 10; k++) begin
         if (exp_q.size() == 0) break;
         @(posedge Clock);
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain left=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
